// File: rtl/g729_basic_op_pkg.sv
// G.729 saturating 32-bit basic operators and the LSP-polynomial FSM state type.
// Each operator returns its result together with a flag that marks a clipped result.
package g729_basic_op_pkg;

    localparam logic [31:0] MAX_32 = 32'h7FFF_FFFF;
    localparam logic [31:0] MIN_32 = 32'h8000_0000;
    localparam logic [31:0] F_INIT = 32'h0100_0000;

    typedef struct packed {
        logic        sat;
        logic [31:0] val;
    } satRes_t;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        COPY,
        INNER,
        TAIL,
        DONE
    } lspPolState_t;

    function automatic satRes_t l_add(input logic [31:0] a, input logic [31:0] b);
        satRes_t     r;
        logic [32:0] s;
        s = {a[31], a} + {b[31], b};
        r.sat = (s[32] != s[31]);
        r.val = r.sat ? (s[32] ? MIN_32 : MAX_32) : s[31:0];
        return r;
    endfunction

    function automatic satRes_t l_sub(input logic [31:0] a, input logic [31:0] b);
        satRes_t     r;
        logic [32:0] s;
        s = {a[31], a} - {b[31], b};
        r.sat = (s[32] != s[31]);
        r.val = r.sat ? (s[32] ? MIN_32 : MAX_32) : s[31:0];
        return r;
    endfunction

    function automatic satRes_t l_shl1(input logic [31:0] x);
        satRes_t r;
        r.sat = (x[31] != x[30]);
        r.val = r.sat ? (x[31] ? MIN_32 : MAX_32) : {x[30:0], 1'b0};
        return r;
    endfunction

    // Only (-1)*(-1) can overflow the doubled 16x16 product.
    function automatic satRes_t l_mult(input logic [15:0] a, input logic [15:0] b);
        satRes_t            r;
        logic signed [31:0] p;
        p = $signed(a) * $signed(b);
        r.sat = (a == 16'h8000) && (b == 16'h8000);
        r.val = r.sat ? MAX_32 : (p <<< 1);
        return r;
    endfunction

    function automatic satRes_t l_msu(input logic [31:0] acc, input logic [15:0] a,
                                      input logic [15:0] b);
        satRes_t m;
        satRes_t r;
        m = l_mult(a, b);
        r = l_sub(acc, m.val);
        r.sat = r.sat | m.sat;
        return r;
    endfunction

endpackage

// File: rtl/mpy_32_16.sv
// Combinational G.729 Mpy_32_16: 32-bit value split into hi/lo halves times a Q15 factor.
// Sets sat when either the hi product or the final accumulation clips.
module mpy_32_16
    import g729_basic_op_pkg::*;
(
    input  logic [31:0] x,
    input  logic [15:0] n,
    output logic [31:0] product,
    output logic        sat
);

    logic signed [31:0] hiExt;
    logic signed [31:0] nExt;
    logic signed [31:0] loFull;
    logic signed [31:0] loMul;
    logic signed [31:0] loTerm;
    satRes_t            hiProd;
    satRes_t            acc;

    assign hiExt  = {{16{x[31]}}, x[31:16]};
    assign nExt   = {{16{n[15]}}, n};
    // lo always lands in 0..32767, so lo*n and its Q15 rescale stay in range.
    assign loFull = ($signed(x) >>> 1) - (hiExt <<< 15);
    assign loMul  = loFull * nExt;
    assign loTerm = (loMul >>> 15) <<< 1;

    always_comb begin
        hiProd  = l_mult(x[31:16], n);
        acc     = l_add(hiProd.val, loTerm);
        product = acc.val;
        sat     = hiProd.sat | acc.sat;
    end

endmodule

// File: rtl/get_lsp_pol_fsm.sv
// Expands five Q15 LSPs into the six Q24 coefficients of F1(z)/F2(z), one MAC step per clock.
// Optional sticky clip flag `ovf` is built only when GET_LSP_POL_SAT_FLAG_EN is defined.
module get_lsp_pol_fsm
    import g729_basic_op_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] lsp1,
    input  logic [15:0] lsp2,
    input  logic [15:0] lsp3,
    input  logic [15:0] lsp4,
    input  logic [15:0] lsp5,
    output logic        done,
    output logic [31:0] f0,
    output logic [31:0] f1,
    output logic [31:0] f2,
    output logic [31:0] f3,
    output logic [31:0] f4,
    output logic [31:0] f5
`ifdef GET_LSP_POL_SAT_FLAG_EN
    ,
    output logic        ovf
`endif
);

    lspPolState_t stateReg, stateNext;
    logic [2:0]   iReg, iNext;
    logic [2:0]   kReg, kNext;
    logic [31:0]  fReg  [0:5];
    logic [31:0]  fNext [0:5];
    logic [15:0]  lspReg [0:4];
    logic [15:0]  lspCur;
    logic [2:0]   kMinus1, kMinus2;
    logic [31:0]  mpyProd;
    logic         mpySat;
    logic         satHit;
    satRes_t      msuRes, sumRes, diffRes, shlRes;

    assign lspCur  = lspReg[3'(iReg - 3'd1)];
    assign kMinus1 = kReg - 3'd1;
    assign kMinus2 = kReg - 3'd2;

    mpy_32_16 uMpy (
        .x       (fReg[kMinus1]),
        .n       (lspCur),
        .product (mpyProd),
        .sat     (mpySat)
    );

    always_comb begin
        stateNext = stateReg;
        iNext     = iReg;
        kNext     = kReg;
        fNext     = fReg;
        satHit    = 1'b0;
        msuRes    = '0;
        sumRes    = '0;
        diffRes   = '0;
        shlRes    = '0;
        case (stateReg)
            IDLE: if (start) stateNext = INIT;
            INIT: begin
                fNext[0]  = F_INIT;
                msuRes    = l_msu(32'd0, lspReg[0], 16'd512);
                fNext[1]  = msuRes.val;
                satHit    = msuRes.sat;
                iNext     = 3'd2;
                stateNext = COPY;
            end
            COPY: begin
                fNext[iReg] = fReg[3'(iReg - 3'd2)];
                kNext       = iReg;
                stateNext   = INNER;
            end
            // Descending k: f[k-1] read here is still the previous-pass value.
            INNER: begin
                shlRes      = l_shl1(mpyProd);
                sumRes      = l_add(fReg[kReg], fReg[kMinus2]);
                diffRes     = l_sub(sumRes.val, shlRes.val);
                fNext[kReg] = diffRes.val;
                satHit      = mpySat | shlRes.sat | sumRes.sat | diffRes.sat;
                if (kReg == 3'd2) stateNext = TAIL;
                else              kNext     = kMinus1;
            end
            TAIL: begin
                msuRes   = l_msu(fReg[1], lspCur, 16'd512);
                fNext[1] = msuRes.val;
                satHit   = msuRes.sat;
                if (iReg == 3'd5) begin
                    stateNext = DONE;
                end else begin
                    iNext     = iReg + 3'd1;
                    stateNext = COPY;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg <= IDLE;
            iReg     <= '0;
            kReg     <= '0;
            for (int j = 0; j < 6; j++) fReg[j] <= '0;
            for (int j = 0; j < 5; j++) lspReg[j] <= '0;
        end else begin
            stateReg <= stateNext;
            iReg     <= iNext;
            kReg     <= kNext;
            fReg     <= fNext;
            if (stateReg == IDLE && start) begin
                lspReg[0] <= lsp1;
                lspReg[1] <= lsp2;
                lspReg[2] <= lsp3;
                lspReg[3] <= lsp4;
                lspReg[4] <= lsp5;
            end
        end
    end

    assign done = (stateReg == DONE);
    assign f0   = fReg[0];
    assign f1   = fReg[1];
    assign f2   = fReg[2];
    assign f3   = fReg[3];
    assign f4   = fReg[4];
    assign f5   = fReg[5];

`ifdef GET_LSP_POL_SAT_FLAG_EN
    logic ovfReg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          ovfReg <= 1'b0;
        else if (stateReg == IDLE && start)  ovfReg <= 1'b0;
        else if (satHit)                     ovfReg <= 1'b1;
    end

    assign ovf = ovfReg;
`else
    logic unusedSat;
    assign unusedSat = satHit;
`endif

endmodule

// File: tb/tb_get_lsp_pol_fsm.sv
// Directed bench for get_lsp_pol_fsm: fixed-latency runs against hand-computed coefficients.
// Covers reset, ignored starts, input changes after acceptance and back-to-back starts.
module tb_get_lsp_pol_fsm;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] lsp1 = '0, lsp2 = '0, lsp3 = '0, lsp4 = '0, lsp5 = '0;
    logic        done;
    logic [31:0] f0, f1, f2, f3, f4, f5;
`ifdef GET_LSP_POL_SAT_FLAG_EN
    logic        ovf;
`endif

    int checkCnt = 0;
    int errCnt   = 0;

    always #5 clk = ~clk;

    get_lsp_pol_fsm dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .lsp1  (lsp1),
        .lsp2  (lsp2),
        .lsp3  (lsp3),
        .lsp4  (lsp4),
        .lsp5  (lsp5),
        .done  (done),
        .f0    (f0),
        .f1    (f1),
        .f2    (f2),
        .f3    (f3),
        .f4    (f4),
        .f5    (f5)
`ifdef GET_LSP_POL_SAT_FLAG_EN
        ,
        .ovf   (ovf)
`endif
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic checkOvf(input string tag, input logic exp);
`ifdef GET_LSP_POL_SAT_FLAG_EN
        checkVal({tag, " ovf"}, {31'd0, ovf}, {31'd0, exp});
`else
        if (exp === 1'bx) $display("no ovf port for %s", tag);
`endif
    endtask

    // Start a run, scramble inputs and keep start high (ignored), then check at cycle 21.
    task automatic runCase(input string tag,
                           input logic [15:0] l1, input logic [15:0] l2, input logic [15:0] l3,
                           input logic [15:0] l4, input logic [15:0] l5,
                           input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                           input logic [31:0] e3, input logic [31:0] e4, input logic [31:0] e5,
                           input bit allF, input logic expOvf);
        int lat;
        bit seen;
        @(negedge clk);
        lsp1 = l1; lsp2 = l2; lsp3 = l3; lsp4 = l4; lsp5 = l5;
        start = 1'b1;
        @(posedge clk);
        #1;
        lsp1 = 16'h1234; lsp2 = 16'h1234; lsp3 = 16'h1234; lsp4 = 16'h1234; lsp5 = 16'h1234;
        lat  = 0;
        seen = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        checkVal({tag, " latency"}, 32'(lat), 32'd20);
        @(negedge clk);
        start = 1'b0;
        checkVal({tag, " done after"}, {31'd0, done}, 32'd0);
        checkVal({tag, " f0"}, f0, e0);
        checkVal({tag, " f1"}, f1, e1);
        if (allF) begin
            checkVal({tag, " f2"}, f2, e2);
            checkVal({tag, " f3"}, f3, e3);
            checkVal({tag, " f4"}, f4, e4);
            checkVal({tag, " f5"}, f5, e5);
        end
        checkOvf(tag, expOvf);
    endtask

    int firstDone, secondDone, doneCnt;
    bit prevDone, doubleDone;

    initial begin
        repeat (2) @(negedge clk);
        checkVal("rst done", {31'd0, done}, 32'd0);
        checkVal("rst f0", f0, 32'd0);
        checkVal("rst f2", f2, 32'd0);
        checkVal("rst f5", f5, 32'd0);
        checkOvf("rst", 1'b0);
        reset = 1'b1;

        runCase("zero", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                32'h0100_0000, 32'h0000_0000, 32'h0500_0000, 32'h0000_0000,
                32'h0A00_0000, 32'h0000_0000, 1'b1, 1'b0);
        runCase("lsp1", 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                32'h0100_0000, 32'hFF00_0000, 32'h0500_0000, 32'hFC00_0000,
                32'h0A00_0000, 32'hFA00_0000, 1'b1, 1'b0);
        runCase("lsp5", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h4000,
                32'h0100_0000, 32'hFF00_0000, 32'h0500_0000, 32'hFC00_0000,
                32'h0A00_0000, 32'hFA00_0000, 1'b1, 1'b0);
        runCase("minus1", 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                32'h0100_0000, 32'h0A00_0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        runCase("zero2", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                32'h0100_0000, 32'h0000_0000, 32'h0500_0000, 32'h0000_0000,
                32'h0A00_0000, 32'h0000_0000, 1'b1, 1'b0);

        // Abort a run with reset in cycle 10.
        @(negedge clk);
        lsp1 = 16'h4000; lsp2 = '0; lsp3 = '0; lsp4 = '0; lsp5 = '0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        checkVal("abort f0", f0, 32'd0);
        checkVal("abort f1", f1, 32'd0);
        checkVal("abort f2", f2, 32'd0);
        checkVal("abort done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        runCase("after abort", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                32'h0100_0000, 32'h0000_0000, 32'h0500_0000, 32'h0000_0000,
                32'h0A00_0000, 32'h0000_0000, 1'b1, 1'b0);

        // start held high: runs accepted at edges 0 and 21.
        @(negedge clk);
        lsp1 = 16'h4000; lsp2 = '0; lsp3 = '0; lsp4 = '0; lsp5 = '0;
        start = 1'b1;
        @(posedge clk);
        firstDone = 0; secondDone = 0; doneCnt = 0;
        prevDone = 1'b0; doubleDone = 1'b0;
        for (int c = 1; c <= 41; c++) begin
            @(negedge clk);
            if (done) begin
                doneCnt++;
                if (prevDone) doubleDone = 1'b1;
                if (firstDone == 0) firstDone = c;
                else                secondDone = c;
            end
            prevDone = done;
        end
        start = 1'b0;
        checkVal("held first done", 32'(firstDone), 32'd20);
        checkVal("held second done", 32'(secondDone), 32'd41);
        checkVal("held done count", 32'(doneCnt), 32'd2);
        checkVal("held no double", {31'd0, doubleDone}, 32'd0);
        @(negedge clk);
        checkVal("held done after", {31'd0, done}, 32'd0);
        checkVal("held f1", f1, 32'hFF00_0000);
        checkVal("held f3", f3, 32'hFC00_0000);
        checkVal("held f5", f5, 32'hFA00_0000);

        $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
        $finish;
    end

endmodule
